// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution MAC slice.
package conv_pkg;

  localparam int PIX_W      = 8;
  localparam int WIN_TAPS   = 9;
  localparam int WIN_ROWS   = 3;
  localparam int IMG_W_DEF  = 32;
  localparam int COEF_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int SHIFT_DEF  = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } conv_state_e;

endpackage

// File: rtl/conv_sat_relu.sv
// Final stage of the MAC: arithmetic scale, ReLU and clamp of the signed sum to an 8-bit pixel.
module conv_sat_relu
  import conv_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [PIX_W-1:0] pixel
);

  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic signed [ACC_W-1:0] scaled;

  always_comb begin
    scaled = sum >>> SHIFT;
    if (scaled < 0) begin
      pixel = '0;
    end else if (scaled > PIX_MAX) begin
      pixel = '1;
    end else begin
      pixel = scaled[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// Signed 3x3 MAC over a streamed window with a run-time loaded kernel; emits one
// ReLU'd, saturated pixel per window, tagged with its output-map coordinate.
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter  int IMG_W  = IMG_W_DEF,
  parameter  int COEF_W = COEF_W_DEF,
  parameter  int ACC_W  = ACC_W_DEF,
  parameter  int SHIFT  = SHIFT_DEF,
  localparam int POS_W  = $clog2(IMG_W - 2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIN_TAPS*PIX_W-1:0] window,
  input  logic                      window_valid,
  input  logic                      coef_load_start,
  input  logic                      coef_we,
  input  logic signed [COEF_W-1:0]  coef_in,
  output logic                      kernel_ready,
  output logic [PIX_W-1:0]          pixel_out,
  output logic                      pixel_valid,
  output logic [POS_W-1:0]          out_col,
  output logic [POS_W-1:0]          out_row,
  output logic                      frame_done
);

  localparam int               PROD_W   = PIX_W + 1 + COEF_W;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(IMG_W - 3);

  conv_state_e              state, state_nxt;
  logic [3:0]               coef_idx;
  logic signed [COEF_W-1:0] kernel [WIN_TAPS];
  logic                     coef_write, take;

  assign coef_write   = (state == LOAD) && coef_we && !coef_load_start;
  assign take         = (state == RUN) && window_valid && !coef_load_start;
  assign kernel_ready = (state == RUN);

  // NOTE: state_nxt gets its default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (coef_load_start) begin
      state_nxt = LOAD;
    end else if (coef_write && coef_idx == 4'(WIN_TAPS - 1)) begin
      state_nxt = RUN;
    end
  end

  // NOTE: registers update with <= so every flop samples pre-edge values regardless of block order.
  // NOTE: the kernel is reset because it defines behaviour; datapath registers below are not, as
  //       their valid bits already say whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      coef_idx <= '0;
      for (int i = 0; i < WIN_TAPS; i++) kernel[i] <= '0;
    end else begin
      state <= state_nxt;
      if (coef_load_start) begin
        coef_idx <= '0;
      end else if (coef_write) begin
        kernel[coef_idx] <= coef_in;
        coef_idx         <= coef_idx + 4'd1;
      end
    end
  end

  logic signed [PROD_W-1:0] pix_ext  [WIN_TAPS];
  logic signed [PROD_W-1:0] coef_ext [WIN_TAPS];
  logic signed [PROD_W-1:0] prod_d   [WIN_TAPS];
  logic signed [PROD_W-1:0] prod_q   [WIN_TAPS];
  logic signed [ACC_W-1:0]  row_d    [WIN_ROWS];
  logic signed [ACC_W-1:0]  row_q    [WIN_ROWS];
  logic signed [ACC_W-1:0]  sum_d;
  logic [PIX_W-1:0]         sat_pixel;

  // Tap 0 is the top-left pixel in the most significant byte; pixels are unsigned.
  always_comb begin
    for (int i = 0; i < WIN_TAPS; i++) begin
      pix_ext[i]  = PROD_W'({1'b0, window[(WIN_TAPS-1-i)*PIX_W +: PIX_W]});
      coef_ext[i] = PROD_W'(kernel[i]);
      prod_d[i]   = pix_ext[i] * coef_ext[i];
    end
    for (int r = 0; r < WIN_ROWS; r++) begin
      row_d[r] = ACC_W'(prod_q[3*r]) + ACC_W'(prod_q[3*r+1]) + ACC_W'(prod_q[3*r+2]);
    end
    sum_d = row_q[0] + row_q[1] + row_q[2];
  end

  conv_sat_relu #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat_relu (
    .sum   (sum_d),
    .pixel (sat_pixel)
  );

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    row_q  <= row_d;
  end

  logic                    s1_valid, s2_valid;
  logic [POS_W-1:0]        next_col, next_row;

  // A kernel reload discards in-flight windows and restarts the raster at (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
      out_col     <= '0;
      out_row     <= '0;
      next_col    <= '0;
      next_row    <= '0;
      frame_done  <= 1'b0;
    end else if (coef_load_start) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      pixel_valid <= 1'b0;
      out_col     <= '0;
      out_row     <= '0;
      next_col    <= '0;
      next_row    <= '0;
      frame_done  <= 1'b0;
    end else begin
      s1_valid    <= take;
      s2_valid    <= s1_valid;
      pixel_valid <= s2_valid;
      frame_done  <= 1'b0;
      if (s2_valid) begin
        pixel_out  <= sat_pixel;
        out_col    <= next_col;
        out_row    <= next_row;
        frame_done <= (next_col == POS_LAST) && (next_row == POS_LAST);
        if (next_col == POS_LAST) begin
          next_col <= '0;
          next_row <= (next_row == POS_LAST) ? '0 : next_row + POS_W'(1);
        end else begin
          next_col <= next_col + POS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomised bench for conv3x3_mac: every cycle is compared against a transaction-level
// model that computes each result directly from the window and the loaded kernel.
module tb_conv3x3_mac;

  localparam int IMG_W   = 32;
  localparam int OUT_W   = IMG_W - 2;
  localparam int N_PIX   = OUT_W * OUT_W;
  localparam int LATENCY = 2;  // window valid in cycle c -> result visible in cycle c+3

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] window;
  logic        window_valid;
  logic        coef_load_start;
  logic        coef_we;
  logic signed [7:0] coef_in;
  logic        kernel_ready;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic [4:0]  out_col;
  logic [4:0]  out_row;
  logic        frame_done;

  conv3x3_mac #(.IMG_W(IMG_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .window          (window),
    .window_valid    (window_valid),
    .coef_load_start (coef_load_start),
    .coef_we         (coef_we),
    .coef_in         (coef_in),
    .kernel_ready    (kernel_ready),
    .pixel_out       (pixel_out),
    .pixel_valid     (pixel_valid),
    .out_col         (out_col),
    .out_row         (out_row),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = loading, 2 = running.
  typedef struct {
    int due;
    int pix;
  } result_t;

  result_t pend[$];
  int k[9];
  int m_idx, m_mode, cyc, pos;
  int last_pix, last_col, last_row;
  int exp_valid, exp_frame;
  int seen_valid, seen_frame;

  function automatic int ref_pixel(input logic [71:0] w);
    int sum = 0;
    for (int i = 0; i < 9; i++) sum += int'(w[71-8*i -: 8]) * k[i];
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return sum;
  endfunction

  task automatic model_edge();
    result_t r;
    cyc++;
    exp_valid = 0;
    exp_frame = 0;
    if (!reset) begin
      m_mode = 0;
      m_idx  = 0;
      for (int i = 0; i < 9; i++) k[i] = 0;
      pend.delete();
      pos = 0; last_pix = 0; last_col = 0; last_row = 0;
    end else if (coef_load_start) begin
      m_mode = 1;
      m_idx  = 0;
      pend.delete();
      pos = 0; last_col = 0; last_row = 0;
    end else begin
      if (m_mode == 2 && window_valid) pend.push_back('{cyc + LATENCY, ref_pixel(window)});
      if (m_mode == 1 && coef_we) begin
        k[m_idx] = int'(coef_in);
        m_idx++;
        if (m_idx == 9) m_mode = 2;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r         = pend.pop_front();
        last_pix  = r.pix;
        last_col  = pos % OUT_W;
        last_row  = pos / OUT_W;
        exp_frame = (pos == N_PIX - 1);
        exp_valid = 1;
        pos       = (pos + 1) % N_PIX;
      end
    end
  endtask

  task automatic compare();
    check("pixel_valid", pixel_valid, exp_valid);
    check("pixel_out", pixel_out, last_pix);
    check("out_col", out_col, last_col);
    check("out_row", out_row, last_row);
    check("frame_done", frame_done, exp_frame);
    check("kernel_ready", kernel_ready, (m_mode == 2));
    if (pixel_valid) seen_valid++;
    if (frame_done) seen_frame++;
  endtask

  task automatic step(input logic rst_v, input logic st, input logic we, input logic [7:0] c,
                      input logic v, input logic [71:0] w);
    reset           = rst_v;
    coef_load_start = st;
    coef_we         = we;
    coef_in         = c;
    window_valid    = v;
    window          = w;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [71:0] mk_win(input int centre, input int others);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[71-8*i -: 8] = (i == 4) ? 8'(centre) : 8'(others);
    return w;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00, 0, '0);
  endtask

  task automatic win(input logic [71:0] w);
    step(1, 0, 0, 8'h00, 1, w);
  endtask

  task automatic load_kernel(input int kv[9]);
    step(1, 1, 0, 8'h00, 0, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 1, 8'(kv[i]), 0, '0);
  endtask

  initial begin
    int kv[9];
    reset = 1'b0; coef_load_start = 1'b0; coef_we = 1'b0; coef_in = '0;
    window_valid = 1'b0; window = '0;
    m_mode = 0; m_idx = 0; cyc = 0; pos = 0;
    last_pix = 0; last_col = 0; last_row = 0; seen_valid = 0; seen_frame = 0;
    for (int i = 0; i < 9; i++) k[i] = 0;

    repeat (3) step(0, 0, 0, 8'h00, 0, '0);
    step(1, 0, 1, 8'h33, 1, rand_win());  // window and write in IDLE: both ignored
    idle(3);

    // Identity kernel: centre passes through with exact latency
    load_kernel('{0, 0, 0, 0, 1, 0, 0, 0, 0});
    win(mk_win(8'h5A, 8'hFF));
    idle(4);

    // Box kernel: saturation and plain sum
    load_kernel('{1, 1, 1, 1, 1, 1, 1, 1, 1});
    win(mk_win(255, 255));
    win(mk_win(10, 10));
    idle(3);

    // Laplacian: zero, clamp high, ReLU
    load_kernel('{-1, -1, -1, -1, 8, -1, -1, -1, -1});
    win(mk_win(100, 100));
    win(mk_win(200, 100));
    win(mk_win(0, 100));
    idle(3);

    // Most negative sum must not wrap
    load_kernel('{-128, -128, -128, -128, -128, -128, -128, -128, -128});
    win(mk_win(255, 255));
    idle(3);

    // Full frame plus one, back to back, random kernel
    for (int i = 0; i < 9; i++) kv[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel(kv);
    seen_valid = 0;
    seen_frame = 0;
    for (int i = 0; i < N_PIX + 1; i++) win(rand_win());
    idle(3);
    check("stream_valid_count", seen_valid, N_PIX + 1);
    check("stream_frame_done_count", seen_frame, 1);

    // Sparse traffic with stray coefficient writes that must be ignored in RUN
    for (int i = 0; i < 200; i++)
      step(1, 0, ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), rand_win());
    idle(3);

    // Reload with windows in flight; windows during LOAD dropped
    for (int i = 0; i < 3; i++) win(rand_win());
    step(1, 1, 0, 8'h00, 1, rand_win());
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 8'($urandom_range(0, 255)), 1, rand_win());
      step(1, 0, 0, 8'h00, 1, rand_win());
    end
    idle(4);
    step(1, 0, 1, 8'($urandom_range(0, 255)), 1, rand_win());
    for (int i = 0; i < 5; i++) win(rand_win());
    idle(3);

    // Start and write together: the write is dropped, next nine fill the kernel
    step(1, 1, 1, 8'h7F, 0, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 1, 8'($urandom_range(0, 255)), 0, '0);
    for (int i = 0; i < 20; i++) win(rand_win());

    // Reset mid-stream, then windows in IDLE go nowhere
    step(0, 0, 0, 8'h00, 1, rand_win());
    for (int i = 0; i < 5; i++) win(rand_win());
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
